// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and state type for the Gray counter interface.
package gray_pkg;

  // Widest Gray count the helpers handle; callers zero-extend narrower values.
  localparam int GW_MAX = 32;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    TRACK = 1'b1
  } gray_rx_state_t;

  // Reflected Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Zero-extended upper bits contribute nothing, so any width up to GW_MAX works.
  function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
    logic [GW_MAX-1:0] b;
    b = '0;
    b[GW_MAX-1] = g[GW_MAX-1];
    for (int i = GW_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to reflected Gray.
  function automatic logic [GW_MAX-1:0] bin2gray(input logic [GW_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits; 6 bits covers 0..GW_MAX.
  function automatic logic [5:0] popcount(input logic [GW_MAX-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < GW_MAX; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the clk domain.
module gray_sync #(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];

  // Next value of each stage: first stage takes the async input, the rest shift.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flop chain with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Receive side of the Gray counter interface: synchronize, decode to binary,
// report per-sample advance and flag multi-bit (illegal) transitions.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2,
  parameter int ECW         = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   gray_in,
  output logic [N-1:0]   bin_out,
  output logic           valid,
  output logic [N-1:0]   delta,
  output logic           step,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);

  localparam int            CW        = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(SYNC_STAGES);
  localparam logic [ECW-1:0] ERR_MAX  = '1;

  logic [N-1:0]   sg;
  logic [N-1:0]   sg_bin_s;
  logic [5:0]     hd_s;

  gray_rx_state_t state_q, state_d;
  logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
  logic [N-1:0]   prev_gray_q, prev_gray_d;
  logic [N-1:0]   bin_q, bin_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   delta_q, delta_d;
  logic           step_q, step_d;
  logic           err_q, err_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  gray_sync #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .q   (sg)
  );

  // Decode the synchronized sample and measure its distance from the previous one.
  always_comb begin
    sg_bin_s = N'(gray2bin(GW_MAX'(sg)));
    hd_s     = popcount(GW_MAX'(sg ^ prev_gray_q));
  end

  // Next-state logic: wait for the synchronizer to fill, then track every sample.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    prev_gray_d = prev_gray_q;
    bin_d       = bin_q;
    valid_d     = valid_q;
    delta_d     = '0;
    step_d      = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      FILL: begin
        // The first real sample only seeds the tracker; no step or err for it.
        if (fill_cnt_q == FILL_LAST) begin
          prev_gray_d = sg;
          bin_d       = sg_bin_s;
          valid_d     = 1'b1;
          state_d     = TRACK;
        end else begin
          fill_cnt_d = fill_cnt_q + CW'(1);
        end
      end
      TRACK: begin
        // Always follow the new sample, even after an error, so we never stall.
        prev_gray_d = sg;
        bin_d       = sg_bin_s;
        if (hd_s == 6'd0) begin
          delta_d = '0;
        end else if (hd_s == 6'd1) begin
          delta_d = sg_bin_s - bin_q;
          step_d  = 1'b1;
        end else begin
          // Delta still reported on error to help debug the source of the jump.
          delta_d = sg_bin_s - bin_q;
          err_d   = 1'b1;
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ECW'(1);
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      prev_gray_q <= '0;
      bin_q       <= '0;
      valid_q     <= 1'b0;
      delta_q     <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      prev_gray_q <= prev_gray_d;
      bin_q       <= bin_d;
      valid_q     <= valid_d;
      delta_q     <= delta_d;
      step_q      <= step_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out = bin_q;
  assign valid   = valid_q;
  assign delta   = delta_q;
  assign step    = step_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Scoreboard bench for gray_rx_decoder (N=5, SYNC_STAGES=2, ECW=2).
module tb_gray_rx_decoder;

  localparam int N   = 5;
  localparam int SS  = 2;
  localparam int ECW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   gray_in = '0;
  logic [N-1:0]   bin_out;
  logic           valid;
  logic [N-1:0]   delta;
  logic           step;
  logic           err;
  logic [ECW-1:0] err_cnt;

  typedef struct packed {
    logic [N-1:0]   bin;
    logic [N-1:0]   delta;
    logic           step;
    logic           err;
    logic [ECW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: last applied Gray value, its binary value and error count.
  logic [N-1:0]   m_gray = '0;
  logic [N-1:0]   m_bin  = '0;
  logic [ECW-1:0] m_cnt  = '0;

  gray_rx_decoder #(
    .N           (N),
    .SYNC_STAGES (SS),
    .ECW         (ECW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gray_in (gray_in),
    .bin_out (bin_out),
    .valid   (valid),
    .delta   (delta),
    .step    (step),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with gray_in held at g, then expect the first sample b after the fill.
  task automatic do_fill(input logic [N-1:0] g, input logic [N-1:0] b);
    exp_t e;
    rst = 1'b1;
    gray_in = g;
    cyc(1);
    checks++;
    if ({bin_out, valid, delta, step, err, err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state: got bin=%0d valid=%0b delta=%0d step=%0b err=%0b cnt=%0d, expected all 0",
               bin_out, valid, delta, step, err, err_cnt);
    end
    rst = 1'b0;
    cyc(2);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_valid_early: got %0b expected 0", valid);
    end
    e.bin = b; e.delta = '0; e.step = 1'b0; e.err = 1'b0; e.cnt = '0;
    sb_q.push_back(e);
    cyc(1);
    e = sb_q.pop_front();
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_valid: got %0b expected 1", valid);
    end
    checks++;
    if ({bin_out, delta, step, err, err_cnt} !== {e.bin, e.delta, e.step, e.err, e.cnt}) begin
      failures++;
      $display("FAIL fill_sample: got bin=%0d delta=%0d step=%0b err=%0b cnt=%0d expected bin=%0d delta=0 step=0 err=0 cnt=0",
               bin_out, delta, step, err, err_cnt, e.bin);
    end
    m_gray = g;
    m_bin  = b;
    m_cnt  = '0;
  endtask

  // Drive Gray value g (binary b), predict the outcome and check it 3 edges later.
  task automatic apply(input logic [N-1:0] g, input logic [N-1:0] b);
    exp_t e;
    int   hd;
    hd     = $countones(g ^ m_gray);
    e.bin  = b;
    e.delta = (hd == 0) ? '0 : N'(b - m_bin);
    e.step = (hd == 1);
    e.err  = (hd > 1);
    e.cnt  = (hd > 1 && m_cnt != {ECW{1'b1}}) ? ECW'(m_cnt + 1'b1) : m_cnt;
    sb_q.push_back(e);
    gray_in = g;
    cyc(2);
    checks++;
    if (bin_out !== m_bin || step !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL latency_hold: got bin=%0d step=%0b err=%0b expected bin=%0d step=0 err=0",
               bin_out, step, err, m_bin);
    end
    cyc(1);
    e = sb_q.pop_front();
    checks++;
    if (bin_out !== e.bin) begin
      failures++;
      $display("FAIL bin_out: got %0d expected %0d", bin_out, e.bin);
    end
    checks++;
    if (delta !== e.delta) begin
      failures++;
      $display("FAIL delta: got %0d expected %0d (bin %0d)", delta, e.delta, e.bin);
    end
    checks++;
    if (step !== e.step || err !== e.err) begin
      failures++;
      $display("FAIL step_err: got step=%0b err=%0b expected step=%0b err=%0b (bin %0d)",
               step, err, e.step, e.err, e.bin);
    end
    checks++;
    if (err_cnt !== e.cnt || valid !== 1'b1) begin
      failures++;
      $display("FAIL err_cnt_valid: got cnt=%0d valid=%0b expected cnt=%0d valid=1",
               err_cnt, valid, e.cnt);
    end
    cyc(1);
    checks++;
    if (step !== 1'b0 || err !== 1'b0 || bin_out !== b || delta !== '0) begin
      failures++;
      $display("FAIL pulse_width: got step=%0b err=%0b bin=%0d delta=%0d expected 0 0 %0d 0",
               step, err, bin_out, delta, b);
    end
    m_gray = g;
    m_bin  = b;
    m_cnt  = e.cnt;
  endtask

  task automatic test_reset();
    do_fill(5'b00000, 5'd0);
    cyc(3);
    checks++;
    if (step !== 1'b0 || err !== 1'b0 || bin_out !== 5'd0) begin
      failures++;
      $display("FAIL idle_after_fill: got step=%0b err=%0b bin=%0d expected 0 0 0", step, err, bin_out);
    end
  endtask

  task automatic test_count_up();
    apply(5'b00000, 5'd0);
    apply(5'b00001, 5'd1);
    apply(5'b00011, 5'd2);
    apply(5'b00010, 5'd3);
    apply(5'b00110, 5'd4);
  endtask

  task automatic test_wrap();
    do_fill(5'b10000, 5'd31);
    apply(5'b00000, 5'd0);
  endtask

  task automatic test_illegal();
    apply(5'b00001, 5'd1);
    apply(5'b00110, 5'd4);
    apply(5'b00111, 5'd5);
    apply(5'b00110, 5'd4);
  endtask

  task automatic test_saturation();
    logic [ECW-1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    do_fill(5'b00000, 5'd0);
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) apply(5'b00011, 5'd2);
      else            apply(5'b00000, 5'd0);
      checks++;
      if (err_cnt !== want[k]) begin
        failures++;
        $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, err_cnt, want[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply(5'b11001, 5'd17);
    do_fill(5'b11110, 5'd20);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_wrap();
    test_illegal();
    test_saturation();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receive end of the team's Gray-coded counter/pointer interface.
- Samples a Gray count produced in another clock domain through a multi-flop synchronizer, then decodes it to binary.
- Reports per-sample advance (delta) and flags illegal transitions, i.e. more than one bit changing between consecutive synchronized samples.
- Sits in the consumer domain of async FIFOs and event counters fed by the team's Gray counter.

Parameters:
- N, 5, width of the Gray count (N >= 2).
- SYNC_STAGES, 2, synchronizer flop depth (>= 2).
- ECW, 4, width of the saturating error counter.

Ports:
- clk  input  1  consumer-domain clock.
- rst  input  1  reset, synchronous, active-high.
- gray_in  input  N  standard reflected Gray count, asynchronous to clk.
- bin_out  output  N  decoded binary value of the latest synchronized sample.
- valid  output  1  high once the pipeline holds a real sample; stays high until reset.
- delta  output  N  (bin_new - bin_prev) mod 2^N for the current sample; 0 when not tracking.
- step  output  1  one-cycle pulse when delta != 0 and no error.
- err  output  1  one-cycle pulse when the Hamming distance between the current and previous synchronized Gray samples is > 1.
- err_cnt  output  ECW  count of err pulses, saturating at 2^ECW-1.

Behaviour:
- Reset (synchronous, active-high): all synchronizer flops, prev_gray, bin_out, delta, step, err, err_cnt = 0; valid = 0; FSM = FILL; fill counter = 0.
- Synchronizer: gray_in passes through SYNC_STAGES flops to give sg. Nothing else samples gray_in directly.
- Decode: b[N-1] = sg[N-1]; b[i] = b[i+1] ^ sg[i], i = N-2..0. Purely combinational from sg into the output register stage.
- Latency: a gray_in change that meets setup at edge k appears on bin_out after edge k+SYNC_STAGES (SYNC_STAGES+1 edges including the capture edge).
- FSM FILL:
  - Counts SYNC_STAGES cycles after reset release.
  - On the terminal count: load prev_gray = sg and bin_out = decode(sg); assert valid; move to TRACK.
  - No step or err is generated for this first sample.
- FSM TRACK, every cycle:
  - hd = popcount(sg ^ prev_gray).
  - hd == 0: step = 0, err = 0, delta = 0.
  - hd == 1: delta = decode(sg) - bin_out (mod 2^N); step = 1.
  - hd > 1: err = 1; err_cnt += 1 unless saturated; step = 0; delta = decode(sg) - bin_out (mod 2^N), reported for debug.
  - In all three cases: bin_out = decode(sg), prev_gray = sg. On error the decoder resynchronizes to the new value and does not stall.
- Wrap-around: Gray 1 followed by N-1 zeros (bin 2^N-1) to all zeros (bin 0) is hd = 1, delta = 1, legal.
- Backward single step (e.g. bin 3 -> 2) is legal: hd = 1, delta = all ones (-1 mod 2^N), step = 1.
- step, err, and delta are registered and valid in the same cycle as the updated bin_out.
- err_cnt saturates: once at 2^ECW-1 it holds, while err still pulses.
- Reset mid-operation: the next cycle matches the reset state exactly; the FSM re-enters FILL; the first post-reset sample raises no err, even if it differs from the pre-reset value.
- Simultaneous error and saturation: err pulses, err_cnt unchanged.

Decomposition:
- Package gray_pkg:
  - function gray2bin(N)
  - function bin2gray(N)
  - function popcount
  - typedef enum {FILL, TRACK} gray_rx_state_t
- Sub-module gray_sync:
  - Parameterised N and SYNC_STAGES flop chain, synchronous reset.
  - Reused by the future Gray transmitter side and by async FIFO pointers.

Test Plan:
- N=5, SYNC_STAGES=2: reset, then hold gray_in = 00000 -> valid rises 3 cycles after rst falls; bin_out = 0; no step or err.
- Drive Gray 00000, 00001, 00011, 00010, 00110, one per 4 cycles -> bin_out 0,1,2,3,4, each 3 cycles after the change; step pulses with delta = 1 each time; err never asserts.
- Wrap: gray_in 10000 (bin 31) then 00000 -> bin_out 31 then 0, delta = 1, step = 1, err = 0.
- Illegal jump: 00001 -> 00110 (hd = 3) -> err pulse, err_cnt = 1, bin_out = 4, delta = 3, step = 0. Then 00111 (hd = 1) -> step, delta = 1, bin_out = 5.
- Saturation, ECW=2: inject 5 illegal jumps -> err pulses 5 times, err_cnt = 1,2,3,3,3.
- Reset mid-run at bin_out = 17 with gray_in held at Gray(20) = 11110 -> all outputs 0 after the reset edge; valid returns after 3 cycles with bin_out = 20; no err, no step.
